// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM-stage data-memory controller:
// word width, timeout counter width and FSM state encoding.
package mem_access_stage_pkg;

    localparam int WORD_W = 16;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        MEM_IDLE   = 2'd0,
        MEM_ACCESS = 2'd1,
        MEM_DONE   = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-bus req/ack handshake between the MEM stage (master) and the
// data memory (slave).
interface mem_access_stage_if;
    import mem_access_stage_pkg::*;

    logic              bus_req;
    logic              bus_we;
    logic [WORD_W-1:0] bus_addr;
    logic [WORD_W-1:0] bus_wdata;
    logic              bus_ack;
    logic [WORD_W-1:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_ack, bus_rdata
    );

endinterface

// File: rtl/mem_access_stage.sv
// MEM-stage controller: turns EX/MEM load/store control into a bounded
// req/ack bus access, stalling the pipeline until it completes or times out.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [WORD_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    mem_access_stage_if.master bus,
    output logic [WORD_W-1:0] mem_rdata,
    output logic              stall,
    output logic              bus_err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 32'd1);

    mem_state_e        state_q,     state_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic              bus_req_q,   bus_req_d;
    logic              bus_we_q,    bus_we_d;
    logic [WORD_W-1:0] bus_addr_q,  bus_addr_d;
    logic [WORD_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [WORD_W-1:0] mem_rdata_q, mem_rdata_d;
    logic              bus_err_q,   bus_err_d;
    logic              mem_op_s;

    assign mem_op_s = mem_read | mem_write;

    // Next-state and next-output logic; every register holds unless overridden.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        mem_rdata_d = mem_rdata_q;
        bus_err_d   = 1'b0;
        case (state_q)
            MEM_IDLE: begin
                if (mem_op_s) begin
                    bus_addr_d  = addr;
                    bus_wdata_d = wdata;
                    bus_we_d    = mem_write;
                    bus_req_d   = 1'b1;
                    cnt_d       = '0;
                    state_d     = MEM_ACCESS;
                end else begin
                    bus_req_d   = 1'b0;
                end
            end
            MEM_ACCESS: begin
                if (bus.bus_ack) begin
                    bus_req_d = 1'b0;
                    if (!bus_we_q) begin
                        mem_rdata_d = bus.bus_rdata;
                    end else begin
                        mem_rdata_d = mem_rdata_q;
                    end
                    state_d = MEM_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    // Dead bus: abort with a zero result and flag the error.
                    bus_req_d   = 1'b0;
                    mem_rdata_d = '0;
                    bus_err_d   = 1'b1;
                    state_d     = MEM_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            MEM_DONE: begin
                state_d = MEM_IDLE;
            end
            default: begin
                state_d   = MEM_IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    // State, counter and output registers, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= MEM_IDLE;
            cnt_q       <= 8'd0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 16'd0;
            bus_wdata_q <= 16'd0;
            mem_rdata_q <= 16'd0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            mem_rdata_q <= mem_rdata_d;
            bus_err_q   <= bus_err_d;
        end
    end

    // Gated by rst so the pipeline is released while the stage is held in reset.
    assign stall = ~rst & (((state_q == MEM_IDLE) & mem_op_s) | (state_q == MEM_ACCESS));

    assign bus.bus_req   = bus_req_q;
    assign bus.bus_we    = bus_we_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_wdata = bus_wdata_q;
    assign mem_rdata     = mem_rdata_q;
    assign bus_err       = bus_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage (TIMEOUT_CYCLES = 15).
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] mem_rdata;
    logic        stall;
    logic        bus_err;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    mem_access_stage_if bus_if ();

    mem_access_stage #(.TIMEOUT_CYCLES(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .addr      (addr),
        .wdata     (wdata),
        .bus       (bus_if),
        .mem_rdata (mem_rdata),
        .stall     (stall),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; addr = 16'h0000; wdata = 16'h0000;
        bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 16'h0000;
        #2;
        total_cnt++; if (bus_if.bus_req !== 1'b0) $display("FAIL rst_req got %0h exp 0", bus_if.bus_req); else pass_cnt++;
        total_cnt++; if (bus_if.bus_we !== 1'b0) $display("FAIL rst_we got %0h exp 0", bus_if.bus_we); else pass_cnt++;
        total_cnt++; if (bus_if.bus_addr !== 16'h0000) $display("FAIL rst_addr got %h exp 0000", bus_if.bus_addr); else pass_cnt++;
        total_cnt++; if (bus_if.bus_wdata !== 16'h0000) $display("FAIL rst_wdata got %h exp 0000", bus_if.bus_wdata); else pass_cnt++;
        total_cnt++; if (mem_rdata !== 16'h0000) $display("FAIL rst_rdata got %h exp 0000", mem_rdata); else pass_cnt++;
        total_cnt++; if (bus_err !== 1'b0) $display("FAIL rst_err got %0h exp 0", bus_err); else pass_cnt++;
        total_cnt++; if (stall !== 1'b0) $display("FAIL rst_stall got %0h exp 0", stall); else pass_cnt++;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_read_zero_wait();
        int stall_cnt = 0;
        int req_cnt = 0;
        mem_read = 1'b1; addr = 16'h0040;
        #1;
        if (stall === 1'b1) stall_cnt++;
        tick();   // ACCESS
        if (stall === 1'b1) stall_cnt++;
        if (bus_if.bus_req === 1'b1) req_cnt++;
        total_cnt++; if (bus_if.bus_addr !== 16'h0040) $display("FAIL rd_addr got %h exp 0040", bus_if.bus_addr); else pass_cnt++;
        total_cnt++; if (bus_if.bus_we !== 1'b0) $display("FAIL rd_we got %0h exp 0", bus_if.bus_we); else pass_cnt++;
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 16'hBEEF;
        tick();   // DONE
        bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 16'h0000;
        if (stall === 1'b1) stall_cnt++;
        if (bus_if.bus_req === 1'b1) req_cnt++;
        total_cnt++; if (mem_rdata !== 16'hBEEF) $display("FAIL rd_rdata got %h exp beef", mem_rdata); else pass_cnt++;
        mem_read = 1'b0;
        tick();   // IDLE
        if (stall === 1'b1) stall_cnt++;
        if (bus_if.bus_req === 1'b1) req_cnt++;
        total_cnt++; if (stall_cnt !== 2) $display("FAIL rd_stall_cycles got %0d exp 2", stall_cnt); else pass_cnt++;
        total_cnt++; if (req_cnt !== 1) $display("FAIL rd_req_cycles got %0d exp 1", req_cnt); else pass_cnt++;
    endtask

    task automatic test_write_wait();
        int stall_cnt = 0;
        int bad_cnt = 0;
        mem_write = 1'b1; addr = 16'h0100; wdata = 16'h1234;
        #1;
        if (stall === 1'b1) stall_cnt++;
        tick();   // ACCESS 1
        addr = 16'hDEAD; wdata = 16'hCAFE;   // registered copies must not follow
        for (int i = 0; i < 4; i++) begin
            if (stall === 1'b1) stall_cnt++;
            if (bus_if.bus_req !== 1'b1 || bus_if.bus_we !== 1'b1 ||
                bus_if.bus_wdata !== 16'h1234 || bus_if.bus_addr !== 16'h0100) bad_cnt++;
            if (i == 3) bus_if.bus_ack = 1'b1;
            tick();
        end
        bus_if.bus_ack = 1'b0;
        total_cnt++; if (bad_cnt !== 0) $display("FAIL wr_bus_stable got %0d bad cycles exp 0", bad_cnt); else pass_cnt++;
        total_cnt++; if (stall_cnt !== 5) $display("FAIL wr_stall_cycles got %0d exp 5", stall_cnt); else pass_cnt++;
        total_cnt++; if (stall !== 1'b0) $display("FAIL wr_done_stall got %0h exp 0", stall); else pass_cnt++;
        total_cnt++; if (bus_if.bus_req !== 1'b0) $display("FAIL wr_done_req got %0h exp 0", bus_if.bus_req); else pass_cnt++;
        total_cnt++; if (mem_rdata !== 16'hBEEF) $display("FAIL wr_rdata got %h exp beef", mem_rdata); else pass_cnt++;
        mem_write = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        int bad_cnt = 0;
        mem_read = 1'b1; addr = 16'h0200;
        tick();   // ACCESS 1
        for (int i = 0; i < 15; i++) begin
            if (bus_if.bus_req !== 1'b1 || bus_err !== 1'b0 || stall !== 1'b1) bad_cnt++;
            tick();
        end
        total_cnt++; if (bad_cnt !== 0) $display("FAIL to_access got %0d bad cycles exp 0", bad_cnt); else pass_cnt++;
        total_cnt++; if (bus_if.bus_req !== 1'b0) $display("FAIL to_req_drop got %0h exp 0", bus_if.bus_req); else pass_cnt++;
        total_cnt++; if (bus_err !== 1'b1) $display("FAIL to_err got %0h exp 1", bus_err); else pass_cnt++;
        total_cnt++; if (mem_rdata !== 16'h0000) $display("FAIL to_rdata got %h exp 0000", mem_rdata); else pass_cnt++;
        mem_read = 1'b0;
        tick();   // IDLE
        total_cnt++; if (bus_err !== 1'b0) $display("FAIL to_err_fall got %0h exp 0", bus_err); else pass_cnt++;
        total_cnt++; if (stall !== 1'b0 || bus_if.bus_req !== 1'b0) $display("FAIL to_idle got stall=%0h req=%0h exp 0 0", stall, bus_if.bus_req); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        mem_read = 1'b1; addr = 16'h0002;
        tick();   // ACCESS
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 16'h00AA;
        tick();   // DONE
        bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 16'h0000;
        total_cnt++; if (mem_rdata !== 16'h00AA) $display("FAIL b2b_load got %h exp 00aa", mem_rdata); else pass_cnt++;
        mem_read = 1'b0; mem_write = 1'b1; addr = 16'h0003; wdata = 16'h5555;
        #1;
        total_cnt++; if (stall !== 1'b0) $display("FAIL b2b_done_stall got %0h exp 0", stall); else pass_cnt++;
        tick();   // IDLE
        total_cnt++; if (bus_if.bus_req !== 1'b0 || stall !== 1'b1) $display("FAIL b2b_idle got req=%0h stall=%0h exp 0 1", bus_if.bus_req, stall); else pass_cnt++;
        tick();   // ACCESS
        total_cnt++; if (bus_if.bus_req !== 1'b1 || bus_if.bus_addr !== 16'h0003 || bus_if.bus_we !== 1'b1)
            $display("FAIL b2b_store_req got req=%0h addr=%h we=%0h exp 1 0003 1", bus_if.bus_req, bus_if.bus_addr, bus_if.bus_we); else pass_cnt++;
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 16'h7777;
        tick();   // DONE
        bus_if.bus_ack = 1'b0;
        total_cnt++; if (mem_rdata !== 16'h00AA) $display("FAIL b2b_rdata_hold got %h exp 00aa", mem_rdata); else pass_cnt++;
        mem_write = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_access();
        mem_read = 1'b1; addr = 16'h0300;
        tick();   // ACCESS 1
        tick();   // ACCESS 2
        total_cnt++; if (bus_if.bus_req !== 1'b1) $display("FAIL rma_req_before got %0h exp 1", bus_if.bus_req); else pass_cnt++;
        #1 rst = 1'b1;
        #1;
        total_cnt++; if (bus_if.bus_req !== 1'b0) $display("FAIL rma_req_async got %0h exp 0", bus_if.bus_req); else pass_cnt++;
        total_cnt++; if (stall !== 1'b0) $display("FAIL rma_stall_async got %0h exp 0", stall); else pass_cnt++;
        total_cnt++; if (bus_err !== 1'b0) $display("FAIL rma_err_async got %0h exp 0", bus_err); else pass_cnt++;
        mem_read = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 16'hFFFF;
        tick();
        bus_if.bus_ack = 1'b0;
        total_cnt++; if (mem_rdata !== 16'h0000) $display("FAIL rma_late_ack got %h exp 0000", mem_rdata); else pass_cnt++;
        tick();
        total_cnt++; if (bus_if.bus_req !== 1'b0 || stall !== 1'b0) $display("FAIL rma_idle got req=%0h stall=%0h exp 0 0", bus_if.bus_req, stall); else pass_cnt++;
    endtask

    task automatic test_conflict_spurious();
        mem_read = 1'b1; mem_write = 1'b1; addr = 16'h0400; wdata = 16'h0A0A;
        tick();   // ACCESS
        total_cnt++; if (bus_if.bus_we !== 1'b1 || bus_if.bus_wdata !== 16'h0A0A) $display("FAIL cf_we got we=%0h wdata=%h exp 1 0a0a", bus_if.bus_we, bus_if.bus_wdata); else pass_cnt++;
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 16'h2222;
        tick();   // DONE
        bus_if.bus_ack = 1'b0;
        total_cnt++; if (mem_rdata !== 16'h0000) $display("FAIL cf_rdata got %h exp 0000", mem_rdata); else pass_cnt++;
        mem_read = 1'b0; mem_write = 1'b0;
        tick();   // IDLE
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 16'h1111;
        tick();
        bus_if.bus_ack = 1'b0;
        total_cnt++; if (mem_rdata !== 16'h0000) $display("FAIL sp_rdata got %h exp 0000", mem_rdata); else pass_cnt++;
        total_cnt++; if (bus_if.bus_req !== 1'b0 || stall !== 1'b0 || bus_err !== 1'b0)
            $display("FAIL sp_state got req=%0h stall=%0h err=%0h exp 0 0 0", bus_if.bus_req, stall, bus_err); else pass_cnt++;
        // A fresh read must still start normally, proving the FSM stayed in IDLE.
        mem_read = 1'b1; addr = 16'h0500;
        tick();
        total_cnt++; if (bus_if.bus_req !== 1'b1 || bus_if.bus_addr !== 16'h0500) $display("FAIL sp_next_req got req=%0h addr=%h exp 1 0500", bus_if.bus_req, bus_if.bus_addr); else pass_cnt++;
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 16'h3C3C;
        tick();
        bus_if.bus_ack = 1'b0; mem_read = 1'b0;
        total_cnt++; if (mem_rdata !== 16'h3C3C) $display("FAIL sp_next_rdata got %h exp 3c3c", mem_rdata); else pass_cnt++;
        tick();
    endtask

    initial begin
        test_reset();
        test_read_zero_wait();
        test_write_wait();
        test_timeout();
        test_back_to_back();
        test_reset_mid_access();
        test_conflict_spurious();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM-stage data-memory controller for the 16-bit pipeline.
- Sits between the EX/MEM pipeline register and the MEM/WB register.
- Turns load/store control from EX/MEM into a req/ack handshake on the data bus.
- Stalls the pipeline until the access completes, then presents read data to the MEM/WB register.
- Bounds every access with a timeout so a dead bus cannot hang the core.

Parameters:
- TIMEOUT_CYCLES, 15, number of ACCESS cycles without bus_ack before the access is aborted (legal range 1..255).

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-high
- mem_read  in  1  load in MEM stage (from EX/MEM)
- mem_write  in  1  store in MEM stage (from EX/MEM)
- addr  in  16  word address (EX/MEM ALU result)
- wdata  in  16  store data
- bus_req  out  1  data-bus request, registered
- bus_we  out  1  1 = write, registered
- bus_addr  out  16  registered address
- bus_wdata  out  16  registered store data
- bus_ack  in  1  slave completion, single-cycle pulse
- bus_rdata  in  16  read data, valid when bus_ack=1
- mem_rdata  out  16  load result to MEM/WB register
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM; hold MEM/WB
- bus_err  out  1  one-cycle pulse when an access timed out

Behaviour:
- FSM has three states: IDLE, ACCESS, DONE. All state and outputs are flopped on posedge clk and cleared asynchronously by rst.
- Reset values:
  - state = IDLE
  - bus_req = 0, bus_we = 0
  - bus_addr = 0, bus_wdata = 0
  - mem_rdata = 0
  - bus_err = 0
  - timeout counter = 0
- IDLE:
  - If mem_read|mem_write: latch addr and wdata into bus_addr and bus_wdata. Set bus_we = mem_write. Set bus_req = 1. Clear the counter. Go to ACCESS.
  - Otherwise stay in IDLE with bus_req = 0.
- ACCESS:
  - bus_req is held at 1; bus_addr, bus_we and bus_wdata are held stable.
  - If bus_ack=1: drop bus_req. On a read, capture bus_rdata into mem_rdata. Go to DONE.
  - Else if counter == TIMEOUT_CYCLES-1: drop bus_req, set mem_rdata = 0, set bus_err = 1, go to DONE.
  - Else increment the counter.
- DONE:
  - Lasts exactly one cycle. The pipeline advances at its closing edge.
  - bus_err falls at the end of DONE.
  - Next state is IDLE unconditionally. The next instruction's request is evaluated in the following IDLE cycle.
- stall is combinational: (IDLE & (mem_read|mem_write)) | ACCESS. It is 0 in DONE.
- Latency:
  - Ack in the first ACCESS cycle gives 3 cycles IDLE→ACCESS→DONE, with stall high for 2 cycles.
  - Each extra wait cycle adds 1 to both.
- mem_rdata holds its value until the next completed read or a timeout. A write does not modify it.
- If mem_read and mem_write are both 1, the access is a write (bus_we = 1).
- bus_ack is ignored outside ACCESS: no capture, no state change.
- rst asserted mid-ACCESS drops bus_req immediately (asynchronous). Any ack arriving afterwards is ignored.
- Counter width is 8 bits, wrap is impossible given the parameter range. Address is word-granular with no alignment checks.

Decomposition:
- Shared cpu package holds:
  - state encoding localparams MEM_IDLE=2'd0, MEM_ACCESS=2'd1, MEM_DONE=2'd2
  - WORD_W=16
- No sub-module; the FSM, counter and output registers stay in a single file.

Test Plan:
1. Read with zero wait: mem_read=1, addr=16'h0040, ack in first ACCESS cycle with bus_rdata=16'hBEEF → bus_req high for 1 cycle with bus_addr=16'h0040 and bus_we=0; stall high for 2 cycles; mem_rdata=16'hBEEF in DONE.
2. Write with 3 wait states: mem_write=1, addr=16'h0100, wdata=16'h1234, ack on the 4th ACCESS cycle → bus_we=1, bus_wdata=16'h1234 stable throughout; stall high for 5 cycles; mem_rdata unchanged from its prior value.
3. Timeout: TIMEOUT_CYCLES=15, mem_read=1, no ack → bus_req drops after 15 ACCESS cycles; bus_err pulses for 1 cycle in DONE; mem_rdata=16'h0000; FSM returns to IDLE.
4. Back-to-back accesses: load 16'h0002 (ack returns 16'h00AA) followed by store 16'h0003 → DONE is followed by IDLE, then a new ACCESS; the second request carries bus_addr=16'h0003 and bus_we=1; mem_rdata stays 16'h00AA.
5. Reset mid-access: rst asserted asynchronously in the 2nd ACCESS cycle → bus_req, stall and bus_err go 0 without waiting for a clock edge; a later ack with bus_rdata=16'hFFFF leaves mem_rdata=16'h0000.
6. Conflicts and spurious ack: mem_read=mem_write=1 → bus_we=1. A bus_ack pulse in IDLE with no request → no state change and mem_rdata unchanged.
